reg_bank_16x16: RTL and testbench

REG_BANK_16X16 -- requirements
Module: reg_bank_16x16

---
 rtl/reg_bank_pkg.sv | 18 +
 rtl/reg_bank_16x16_wb_fifo.sv | 84 ++++++++
 rtl/reg_bank_16x16.sv | 115 +++++++++++
 tb/tb_reg_bank_16x16.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// Shared constants and types for the 16-entry register bank with its
// write buffer.
//   N_REGS      number of architectural registers
//   ADDR_W      register index width
//   DEF_WIDTH   default data word width
//   DEF_DEPTH   default write-buffer entry count
//   wb_entry_t  one buffered write {addr, data} at the default width
package reg_bank_pkg;
  localparam int N_REGS    = 16;
  localparam int ADDR_W    = 4;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 2;

  typedef struct packed {
    logic [ADDR_W-1:0]    addr;
    logic [DEF_WIDTH-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/reg_bank_16x16_wb_fifo.sv
// wb_fifo: parameterised synchronous FIFO holding pending register writes.
// Ports:
//   clk, rst              clock, synchronous active-high reset (control only)
//   push, push_addr/data  append an entry at the tail (caller guarantees !full)
//   pop                   drop the head entry (caller guarantees count != 0)
//   full, count           occupancy
//   head_addr, head_data  entry at the head, valid while count != 0
//   ent_vld, ent_addr     per-slot view used to build the busy vector
module wb_fifo
  import reg_bank_pkg::*;
#(
  parameter  int W     = DEF_WIDTH,
  parameter  int DEPTH = DEF_DEPTH,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [W-1:0]      push_data,
  input  logic              pop,
  output logic              full,
  output logic [CNT_W-1:0]  count,
  output logic [ADDR_W-1:0] head_addr,
  output logic [W-1:0]      head_data,
  output logic [DEPTH-1:0]  ent_vld,
  output logic [ADDR_W-1:0] ent_addr [DEPTH]
);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [W-1:0]      data_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  // Pointers wrap modulo DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  assign full      = (count == CNT_W'(DEPTH));
  assign head_addr = addr_q[rd_ptr];
  assign head_data = data_q[rd_ptr];

  always_comb begin
    for (int e = 0; e < DEPTH; e++) ent_addr[e] = addr_q[e];
  end

  // Control state: pointers, occupancy and slot valid flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ent_vld <= '0;
    end else begin
      if (push) begin
        wr_ptr          <= ptr_next(wr_ptr);
        ent_vld[wr_ptr] <= 1'b1;
      end
      // With count in 1..DEPTH-1 the two pointers differ, so a same-edge
      // push and pop never touch the same slot flag.
      if (pop) begin
        rd_ptr          <= ptr_next(rd_ptr);
        ent_vld[rd_ptr] <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage carries no reset; slots are only read when valid.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr] <= push_addr;
      data_q[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/reg_bank_16x16.sv
// reg_bank_16x16: sixteen n-bit registers written through a DEPTH-entry
// FIFO write buffer. Requests enter the buffer on a valid/ready handshake and
// retire in order into the bank on edges where commit_en is high.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   wb_valid, wb_ready  write request handshake (ready = buffer not full)
//   wb_addr, wb_data    destination register and data
//   commit_en           allow the buffer head to retire this edge
//   r0..r15             committed register contents, straight from the flops
//   busy                bit i set while a buffered entry targets register i
//   wb_count            number of buffered entries
module reg_bank_16x16
  import reg_bank_pkg::*;
#(
  parameter int n     = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [n-1:0]      wb_data,
  input  logic              commit_en,
  output logic [n-1:0]      r0,
  output logic [n-1:0]      r1,
  output logic [n-1:0]      r2,
  output logic [n-1:0]      r3,
  output logic [n-1:0]      r4,
  output logic [n-1:0]      r5,
  output logic [n-1:0]      r6,
  output logic [n-1:0]      r7,
  output logic [n-1:0]      r8,
  output logic [n-1:0]      r9,
  output logic [n-1:0]      r10,
  output logic [n-1:0]      r11,
  output logic [n-1:0]      r12,
  output logic [n-1:0]      r13,
  output logic [n-1:0]      r14,
  output logic [n-1:0]      r15,
  output logic [N_REGS-1:0] busy,
  output logic [1:0]        wb_count
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              full;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] head_addr;
  logic [n-1:0]      head_data;
  logic [DEPTH-1:0]  ent_vld;
  logic [ADDR_W-1:0] ent_addr [DEPTH];
  logic              accept;
  logic              retire;
  logic [n-1:0]      bank [N_REGS];

  // Ready looks only at occupancy, so a full buffer holds off a request
  // even when the head is retiring on the same edge.
  assign wb_ready = !full;
  assign accept   = wb_valid && wb_ready;
  assign retire   = commit_en && (count != '0);
  assign wb_count = 2'(count);

  wb_fifo #(
    .W     (n),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (accept),
    .push_addr (wb_addr),
    .push_data (wb_data),
    .pop       (retire),
    .full      (full),
    .count     (count),
    .head_addr (head_addr),
    .head_data (head_data),
    .ent_vld   (ent_vld),
    .ent_addr  (ent_addr)
  );

  always_comb begin
    busy = '0;
    for (int e = 0; e < DEPTH; e++) begin
      if (ent_vld[e]) busy[ent_addr[e]] = 1'b1;
    end
  end

  // Bank with its write decoder; only the retiring head can write it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_REGS; i++) bank[i] <= '0;
    end else if (retire) begin
      bank[head_addr] <= head_data;
    end
  end

  assign r0  = bank[0];
  assign r1  = bank[1];
  assign r2  = bank[2];
  assign r3  = bank[3];
  assign r4  = bank[4];
  assign r5  = bank[5];
  assign r6  = bank[6];
  assign r7  = bank[7];
  assign r8  = bank[8];
  assign r9  = bank[9];
  assign r10 = bank[10];
  assign r11 = bank[11];
  assign r12 = bank[12];
  assign r13 = bank[13];
  assign r14 = bank[14];
  assign r15 = bank[15];

endmodule

// File: tb/tb_reg_bank_16x16.sv
// Self-checking bench for reg_bank_16x16: a directed vector table, a
// register-to-mux sweep, and a randomized run against a queue-based model.
module tb_reg_bank_16x16;
  import reg_bank_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_valid = 1'b0;
  logic        wb_ready;
  logic [3:0]  wb_addr = '0;
  logic [15:0] wb_data = '0;
  logic        commit_en = 1'b0;
  logic [15:0] r0, r1, r2, r3, r4, r5, r6, r7;
  logic [15:0] r8, r9, r10, r11, r12, r13, r14, r15;
  logic [15:0] busy;
  logic [1:0]  wb_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reg_bank_16x16 #(.n(16), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_addr(wb_addr), .wb_data(wb_data), .commit_en(commit_en),
    .r0(r0), .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5), .r6(r6), .r7(r7),
    .r8(r8), .r9(r9), .r10(r10), .r11(r11), .r12(r12), .r13(r13),
    .r14(r14), .r15(r15), .busy(busy), .wb_count(wb_count)
  );

  logic [15:0] rv [16];
  assign rv[0] = r0;   assign rv[1] = r1;   assign rv[2] = r2;   assign rv[3] = r3;
  assign rv[4] = r4;   assign rv[5] = r5;   assign rv[6] = r6;   assign rv[7] = r7;
  assign rv[8] = r8;   assign rv[9] = r9;   assign rv[10] = r10; assign rv[11] = r11;
  assign rv[12] = r12; assign rv[13] = r13; assign rv[14] = r14; assign rv[15] = r15;

  // Behavioural 16:1 read mux fed by the register outputs.
  logic [3:0]  sel = '0;
  logic [15:0] y;
  assign y = rv[sel];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [3:0] a,
                       input logic [15:0] d, input logic c);
    @(negedge clk);
    rst = r; wb_valid = v; wb_addr = a; wb_data = d; commit_en = c;
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        r;
    logic        v;
    logic [3:0]  a;
    logic [15:0] d;
    logic        c;
    logic        exp_ready;
    logic [1:0]  exp_cnt;
    logic [15:0] exp_busy;
    int          reg_idx;
    logic [15:0] exp_val;
  } vec_t;

  vec_t vecs [40];
  int   nv = 0;

  task automatic add(input logic r, input logic v, input logic [3:0] a,
                     input logic [15:0] d, input logic c, input logic er,
                     input logic [1:0] ec, input logic [15:0] eb,
                     input int ri, input logic [15:0] ev);
    vecs[nv] = '{r, v, a, d, c, er, ec, eb, ri, ev};
    nv++;
  endtask

  // Reference model state.
  wb_entry_t   q [$];
  logic [15:0] mregs [16];

  initial begin
    // Inputs applied before the edge; expectations hold after it.
    //  rst v  addr data      c  ready cnt busy     reg value
    add(1, 0, 0,  16'h0000, 0, 1, 0, 16'h0000, 0,  16'h0000);
    add(0, 1, 4,  16'h1234, 0, 1, 1, 16'h0010, 4,  16'h0000);
    add(0, 1, 5,  16'h5678, 0, 0, 2, 16'h0030, 5,  16'h0000);
    add(1, 1, 6,  16'h9999, 1, 1, 0, 16'h0000, 4,  16'h0000);
    add(0, 0, 0,  16'h0000, 1, 1, 0, 16'h0000, 5,  16'h0000);
    add(0, 1, 6,  16'h6666, 0, 1, 1, 16'h0040, 6,  16'h0000);
    add(1, 1, 9,  16'h5555, 1, 1, 0, 16'h0000, 6,  16'h0000);
    add(0, 0, 0,  16'h0000, 1, 1, 0, 16'h0000, 9,  16'h0000);
    add(0, 0, 0,  16'h0000, 1, 1, 0, 16'h0000, 6,  16'h0000);
    add(0, 1, 3,  16'hA5A5, 1, 1, 1, 16'h0008, 3,  16'h0000);
    add(0, 0, 0,  16'h0000, 1, 1, 0, 16'h0000, 3,  16'hA5A5);
    add(0, 1, 1,  16'h1111, 0, 1, 1, 16'h0002, 1,  16'h0000);
    add(0, 1, 2,  16'h2222, 0, 0, 2, 16'h0006, 2,  16'h0000);
    add(0, 1, 10, 16'h9999, 0, 0, 2, 16'h0006, 10, 16'h0000);
    add(0, 1, 10, 16'h9999, 1, 1, 1, 16'h0004, 1,  16'h1111);
    add(0, 0, 0,  16'h0000, 1, 1, 0, 16'h0000, 2,  16'h2222);
    add(0, 0, 0,  16'h0000, 1, 1, 0, 16'h0000, 10, 16'h0000);
    add(0, 1, 8,  16'h0808, 0, 1, 1, 16'h0100, 8,  16'h0000);
    add(0, 1, 15, 16'hFFFE, 1, 1, 1, 16'h8000, 8,  16'h0808);
    add(0, 0, 0,  16'h0000, 1, 1, 0, 16'h0000, 15, 16'hFFFE);
    add(0, 1, 7,  16'h0001, 0, 1, 1, 16'h0080, 7,  16'h0000);
    add(0, 1, 7,  16'h0002, 0, 0, 2, 16'h0080, 7,  16'h0000);
    add(0, 0, 0,  16'h0000, 1, 1, 1, 16'h0080, 7,  16'h0001);
    add(0, 0, 0,  16'h0000, 1, 1, 0, 16'h0000, 7,  16'h0002);
    add(0, 0, 0,  16'h0000, 1, 1, 0, 16'h0000, 7,  16'h0002);
    add(0, 1, 0,  16'hBEEF, 1, 1, 1, 16'h0001, 0,  16'h0000);
    add(0, 0, 0,  16'h0000, 1, 1, 0, 16'h0000, 0,  16'hBEEF);
    add(0, 0, 0,  16'h0000, 0, 1, 0, 16'h0000, 3,  16'hA5A5);

    for (int i = 0; i < nv; i++) begin
      drive(vecs[i].r, vecs[i].v, vecs[i].a, vecs[i].d, vecs[i].c);
      edge_sample();
      chk($sformatf("vec%0d_ready", i), 32'(wb_ready), 32'(vecs[i].exp_ready));
      chk($sformatf("vec%0d_count", i), 32'(wb_count), 32'(vecs[i].exp_cnt));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
      chk($sformatf("vec%0d_r%0d", i, vecs[i].reg_idx), 32'(rv[vecs[i].reg_idx]),
          32'(vecs[i].exp_val));
    end

    // Mux sweep: register i holds ~(1<<i), read back through the 16:1 mux.
    drive(1, 0, 0, 16'h0, 0);
    edge_sample();
    for (int i = 0; i < 16; i++) begin
      int guard;
      logic [15:0] pat;
      pat = ~(16'h0001 << i);
      guard = 0;
      while (!wb_ready && guard < 8) begin
        drive(0, 0, 0, 16'h0, 1);
        edge_sample();
        guard++;
      end
      if (!wb_ready) chk("sweep_ready_timeout", 32'(wb_ready), 32'd1);
      drive(0, 1, 4'(i), pat, 1);
      edge_sample();
    end
    drive(0, 0, 0, 16'h0, 1);
    edge_sample();
    drive(0, 0, 0, 16'h0, 0);
    edge_sample();
    chk("sweep_drained", 32'(wb_count), 32'd0);
    for (int s = 0; s < 16; s++) begin
      logic [15:0] want;
      want = ~(16'h0001 << s);
      sel = 4'(s);
      #1;
      chk($sformatf("mux_s%0d", s), 32'(y), 32'(want));
    end

    // Randomized run against the queue model.
    drive(1, 0, 0, 16'h0, 0);
    edge_sample();
    q.delete();
    for (int i = 0; i < 16; i++) mregs[i] = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic r, v, c, acc;
      logic [3:0]  a;
      logic [15:0] d, eb;
      wb_entry_t   e;
      r = ($urandom_range(0, 39) == 0);
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 2) != 0);
      a = 4'($urandom_range(0, 15));
      d = 16'($urandom);
      drive(r, v, a, d, c);
      #1;
      chk($sformatf("rnd%0d_ready", cyc), 32'(wb_ready), 32'(q.size() < 2));
      if (r) begin
        q.delete();
        for (int i = 0; i < 16; i++) mregs[i] = '0;
      end else begin
        acc = v && (q.size() < 2);
        if (c && q.size() > 0) begin
          e = q.pop_front();
          mregs[e.addr] = e.data;
        end
        if (acc) q.push_back('{addr: a, data: d});
      end
      edge_sample();
      eb = '0;
      foreach (q[k]) eb[q[k].addr] = 1'b1;
      chk($sformatf("rnd%0d_count", cyc), 32'(wb_count), 32'(q.size()));
      chk($sformatf("rnd%0d_busy", cyc), 32'(busy), 32'(eb));
      for (int i = 0; i < 16; i++)
        chk($sformatf("rnd%0d_r%0d", cyc, i), 32'(rv[i]), 32'(mregs[i]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
